dvfs_actuator: RTL and testbench

//   Consumer side of the power-management unit's per-domain V/F control codes.

---
 rtl/dvfs_actuator.sv | 72 +++++++
 tb/tb_dvfs_actuator.sv | 136 +++++++++++++
 2 files changed

// File: rtl/dvfs_actuator.sv
// dvfs_actuator: applies a target V/F pair with voltage-before-frequency sequencing and settle/lock waits
module dvfs_actuator #(
  parameter int         SETTLE_CYC = 4,
  parameter int         LOCK_CYC   = 8,
  parameter logic [1:0] V_RESET    = 2'b01,
  parameter logic [2:0] F_RESET    = 3'b010,
  parameter int         CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_v,
  input  logic [2:0] req_f,
  output logic       req_ready,
  output logic [1:0] v_applied,
  output logic [2:0] f_applied,
  output logic       clk_en,
  output logic       busy,
  output logic       done
);
  localparam logic [2:0] IDLE = 3'd0, V_UP = 3'd1, V_UWAIT = 3'd2, F_STEP = 3'd3,
                         F_LOCK = 3'd4, V_DN = 3'd5, V_DWAIT = 3'd6, DONE = 3'd7;
  logic [2:0] state, nxt, ft, div;
  logic [1:0] vt;
  logic [CNT_W-1:0] cnt;
  logic hs, cnt_z;
  assign req_ready = state == IDLE;
  assign busy = !req_ready;
  assign done = state == DONE;
  assign hs = req_valid && req_ready;
  assign cnt_z = cnt == '0;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (hs) nxt = req_v > v_applied ? V_UP : req_f != f_applied ? F_STEP :
                             req_v < v_applied ? V_DN : DONE;
      V_UP:    nxt = V_UWAIT;
      V_UWAIT: if (cnt_z) nxt = v_applied < vt ? V_UP : ft != f_applied ? F_STEP : DONE;
      F_STEP:  nxt = F_LOCK;
      F_LOCK:  if (cnt_z) nxt = vt < v_applied ? V_DN : DONE;
      V_DN:    nxt = V_DWAIT;
      V_DWAIT: if (cnt_z) nxt = v_applied > vt ? V_DN : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      v_applied <= V_RESET;
      f_applied <= F_RESET;
      vt        <= V_RESET;
      ft        <= F_RESET;
      cnt       <= '0;
      div       <= '0;
      clk_en    <= 1'b0;
    end else begin
      state <= nxt;
      if (hs) begin
        vt <= req_v;
        ft <= req_f;
      end
      if (state == V_UP) v_applied <= v_applied + 2'd1;
      if (state == V_DN) v_applied <= v_applied - 2'd1;
      if (state == F_STEP) f_applied <= ft;
      // wait counter is loaded on entry to a wait state and counts down to zero
      cnt <= (state == V_UP || state == V_DN) ? CNT_W'(SETTLE_CYC - 1) :
             state == F_STEP ? CNT_W'(LOCK_CYC - 1) : cnt_z ? cnt : cnt - 1'b1;
      div <= state == F_LOCK ? 3'd0 : div == 3'd0 ? 3'd7 - f_applied : div - 3'd1;
      clk_en <= state != F_LOCK && div == 3'd0;
    end
  end
endmodule

// File: tb/tb_dvfs_actuator.sv
// tb_dvfs_actuator: directed and random V/F transactions checked against a per-cycle trace model
module tb_dvfs_actuator;
  localparam int SETTLE = 4, LOCK = 8;
  logic clk = 0, rst_n = 0, req_valid = 0;
  logic [1:0] req_v = 0;
  logic [2:0] req_f = 0;
  logic req_ready, clk_en, busy, done;
  logic [1:0] v_applied;
  logic [2:0] f_applied;
  int checks = 0, errors = 0;
  logic [1:0] mv;
  logic [2:0] mf, mdiv;
  logic mce;
  typedef struct {logic [1:0] v; logic [2:0] f; bit lock; bit dn;} cyc_t;

  dvfs_actuator #(.SETTLE_CYC(SETTLE), .LOCK_CYC(LOCK), .V_RESET(2'b01), .F_RESET(3'b010), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_v(req_v), .req_f(req_f),
    .req_ready(req_ready), .v_applied(v_applied), .f_applied(f_applied),
    .clk_en(clk_en), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_v", 8'(v_applied), 8'h1);
    chk("rst_f", 8'(f_applied), 8'h2);
    chk("rst_clk_en", 8'(clk_en), 8'h0);
    chk("rst_done", 8'(done), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_ready", 8'(req_ready), 8'h1);
  endtask

  // one clock cycle: check outputs at the negedge, then advance the clock-enable model past the posedge
  task automatic cyc(input logic [1:0] v, input logic [2:0] f, input bit lock, input bit dn, input bit bsy);
    chk("v_applied", 8'(v_applied), 8'(v));
    chk("f_applied", 8'(f_applied), 8'(f));
    chk("clk_en", 8'(clk_en), 8'(mce));
    chk("done", 8'(done), 8'(dn));
    chk("busy", 8'(busy), 8'(bsy));
    chk("req_ready", 8'(req_ready), 8'(!bsy));
    @(posedge clk);
    if (lock) begin
      mce = 1'b0;
      mdiv = 3'd0;
    end else begin
      mce = mdiv == 3'd0;
      mdiv = mdiv == 3'd0 ? 3'd7 - f : mdiv - 3'd1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 0;
    repeat (n) cyc(mv, mf, 0, 0, 0);
  endtask

  // abort_at > 0 asserts reset just before that trace cycle
  task automatic xact(input logic [1:0] vt, input logic [2:0] ft, input int abort_at);
    cyc_t q[$];
    logic [1:0] v = mv;
    logic [2:0] f = mf;
    req_valid = 1;
    req_v = vt;
    req_f = ft;
    cyc(mv, mf, 0, 0, 0);
    req_v = 2'($urandom_range(3, 0));
    req_f = 3'($urandom_range(7, 0));
    while (v < vt) begin
      q.push_back('{v, f, 1'b0, 1'b0});
      v++;
      repeat (SETTLE) q.push_back('{v, f, 1'b0, 1'b0});
    end
    if (f != ft) begin
      q.push_back('{v, f, 1'b0, 1'b0});
      f = ft;
      repeat (LOCK) q.push_back('{v, f, 1'b1, 1'b0});
    end
    while (v > vt) begin
      q.push_back('{v, f, 1'b0, 1'b0});
      v--;
      repeat (SETTLE) q.push_back('{v, f, 1'b0, 1'b0});
    end
    q.push_back('{v, f, 1'b0, 1'b1});
    for (int i = 0; i < q.size(); i++) begin
      if (abort_at != 0 && i == abort_at) begin
        rst_n = 0;
        #1 chk_reset();
        req_valid = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        mv = 2'd1;
        mf = 3'd2;
        mdiv = 3'd0;
        mce = 1'b0;
        return;
      end
      cyc(q[i].v, q[i].f, q[i].lock, q[i].dn, 1);
    end
    mv = v;
    mf = f;
  endtask

  initial begin
    mv = 2'd1;
    mf = 3'd2;
    mdiv = 3'd0;
    mce = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset();
    rst_n = 1;
    idle(10);
    xact(2'd3, 3'd7, 0);
    idle(3);
    xact(2'd0, 3'd0, 0);
    xact(2'd1, 3'd2, 0);
    xact(2'd1, 3'd2, 0);
    xact(2'd2, 3'd2, 0);
    idle(2);
    xact(2'd3, 3'd5, 3);
    idle(5);
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(3, 0) == 0) idle(int'($urandom_range(4, 1)));
      xact(2'($urandom_range(3, 0)), 3'($urandom_range(7, 0)), 0);
    end
    idle(8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
